// File: rtl/pipe_hazard_if.sv
// Hazard request/response bundle between pipeline stages and the stall/flush scheduler.
// master = pipeline side raising requests, slave = scheduler driving stall/flush.
`timescale 1ns/1ps
interface pipe_hazard_if;
  logic        id_stallreq_i;
  logic        ex_stallreq_i;
  logic        branch_flush_i;
  logic [31:0] branch_target_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        ex_timeout_o;
  logic [31:0] perf_stall_cnt_o;
  logic [31:0] perf_flush_cnt_o;

  modport master (
    output id_stallreq_i, ex_stallreq_i, branch_flush_i, branch_target_i,
    input  stall_o, flush_o, new_pc_o, ex_timeout_o, perf_stall_cnt_o, perf_flush_cnt_o
  );

  modport slave (
    input  id_stallreq_i, ex_stallreq_i, branch_flush_i, branch_target_i,
    output stall_o, flush_o, new_pc_o, ex_timeout_o, perf_stall_cnt_o, perf_flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline stall/flush scheduler: same-cycle stall/flush response, watchdog-bounded EX stalls.
// Optional PIPE_PERF_CNT_EN builds free-running stall/flush cycle counters.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_EX_STALL = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 7
) (
  input  logic         clk,
  input  logic         rst,
  pipe_hazard_if.slave hz
);

  typedef enum logic [2:0] {RUN, LU_STALL, EX_STALL, EX_ABORT, FLUSH} state_t;

  localparam logic [5:0]       STALL_LU = 6'b000111;
  localparam logic [5:0]       STALL_EX = 6'b001111;
  localparam logic [CNT_W-1:0] EX_MAX   = CNT_W'(MAX_EX_STALL);
  localparam logic [3:0]       FL_LAST  = 4'(FLUSH_CYCLES - 1);
  localparam bit               FL_MULTI = (FLUSH_CYCLES > 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] excnt_q, excnt_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [31:0]      target_q, target_d;
  logic             timeout_q, timeout_d;
  logic [5:0]       stall_c;
  logic             flush_c;
  logic [31:0]      new_pc_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      excnt_q   <= '0;
      fcnt_q    <= '0;
      target_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      excnt_q   <= excnt_d;
      fcnt_q    <= fcnt_d;
      target_q  <= target_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    excnt_d   = excnt_q;
    fcnt_d    = fcnt_q;
    target_d  = target_q;
    timeout_d = timeout_q;
    stall_c   = '0;
    flush_c   = 1'b0;
    new_pc_c  = target_q;

    if (state_q == FLUSH) begin
      // Every request is dropped while the flush window runs out.
      flush_c = 1'b1;
      if (fcnt_q >= FL_LAST) begin
        state_d = RUN;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end
    end else if (hz.branch_flush_i) begin
      flush_c  = 1'b1;
      new_pc_c = hz.branch_target_i;
      target_d = hz.branch_target_i;
      excnt_d  = '0;
      fcnt_d   = 4'd1;
      state_d  = FL_MULTI ? FLUSH : RUN;
    end else if (state_q == EX_STALL) begin
      if (hz.ex_stallreq_i) begin
        if (excnt_q < EX_MAX) begin
          stall_c = STALL_EX;
          excnt_d = excnt_q + CNT_W'(1);
        end else begin
          timeout_d = 1'b1;
          excnt_d   = '0;
          state_d   = EX_ABORT;
        end
      end else begin
        excnt_d = '0;
        if (hz.id_stallreq_i) begin
          stall_c = STALL_LU;
          state_d = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
    end else if (state_q == EX_ABORT) begin
      if (!hz.ex_stallreq_i)
        state_d = RUN;
    end else if (hz.ex_stallreq_i) begin
      stall_c = STALL_EX;
      excnt_d = CNT_W'(1);
      state_d = EX_STALL;
    end else if (hz.id_stallreq_i && state_q == RUN) begin
      // The bubble is inserted once; in LU_STALL the load has reached MEM and forwarding covers it.
      stall_c = STALL_LU;
      state_d = LU_STALL;
    end else begin
      state_d = RUN;
    end
  end

  assign hz.stall_o      = rst ? 6'd0  : stall_c;
  assign hz.flush_o      = rst ? 1'b0  : flush_c;
  assign hz.new_pc_o     = rst ? 32'd0 : new_pc_c;
  assign hz.ex_timeout_o = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_c != 6'd0) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_c)         perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign hz.perf_stall_cnt_o = perf_stall_q;
  assign hz.perf_flush_cnt_o = perf_flush_q;
`else
  assign hz.perf_stall_cnt_o = 32'd0;
  assign hz.perf_flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: default-parameter instance for general behaviour, MAX_EX_STALL=4 instance for the watchdog.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  logic        clk;
  logic        rst;
  logic        id_req, ex_req, br_req;
  logic [31:0] br_tgt;
  int          vectors;
  int          miscompares;

  pipe_hazard_if bus ();
  pipe_hazard_if bus_wd ();

  assign bus.id_stallreq_i      = id_req;
  assign bus.ex_stallreq_i      = ex_req;
  assign bus.branch_flush_i     = br_req;
  assign bus.branch_target_i    = br_tgt;
  assign bus_wd.id_stallreq_i   = id_req;
  assign bus_wd.ex_stallreq_i   = ex_req;
  assign bus_wd.branch_flush_i  = br_req;
  assign bus_wd.branch_target_i = br_tgt;

  pipe_hazard_ctrl dut (.clk(clk), .rst(rst), .hz(bus));
  pipe_hazard_ctrl #(.MAX_EX_STALL(4)) dut_wd (.clk(clk), .rst(rst), .hz(bus_wd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic ex, input logic br, input logic [31:0] tgt);
    id_req = id; ex_req = ex; br_req = br; br_tgt = tgt;
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h123);
    vectors++; if (bus.stall_o !== 6'd0) begin miscompares++; $display("FAIL rst_stall got %b want 000000", bus.stall_o); end
    vectors++; if (bus.flush_o !== 1'b0) begin miscompares++; $display("FAIL rst_flush got %b want 0", bus.flush_o); end
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus.stall_o !== 6'd0) begin miscompares++; $display("FAIL post_rst_stall got %b want 000000", bus.stall_o); end
    vectors++; if (bus.new_pc_o !== 32'd0) begin miscompares++; $display("FAIL post_rst_new_pc got %h want 0", bus.new_pc_o); end
    vectors++; if (bus.ex_timeout_o !== 1'b0) begin miscompares++; $display("FAIL post_rst_timeout got %b want 0", bus.ex_timeout_o); end
    vectors++; if (bus.perf_stall_cnt_o !== 32'd0) begin miscompares++; $display("FAIL post_rst_perf got %h want 0", bus.perf_stall_cnt_o); end
  endtask

  task automatic test_load_use();
    logic [5:0] exp [4] = '{6'b000111, 6'b000000, 6'b000111, 6'b000000};
    for (int c = 0; c < 4; c++) begin
      drive(c < 3, 1'b0, 1'b0, 32'h0);
      vectors++; if (bus.stall_o !== exp[c]) begin miscompares++; $display("FAIL load_use_c%0d got %b want %b", c, bus.stall_o, exp[c]); end
      tick();
    end
  endtask

  task automatic test_ex_stall();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      vectors++; if (bus.stall_o !== 6'b001111) begin miscompares++; $display("FAIL ex_stall_c%0d got %b want 001111", c, bus.stall_o); end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus.stall_o !== 6'b000111) begin miscompares++; $display("FAIL ex_release_lu got %b want 000111", bus.stall_o); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus.stall_o !== 6'd0) begin miscompares++; $display("FAIL ex_after_lu got %b want 000000", bus.stall_o); end
    vectors++; if (bus.ex_timeout_o !== 1'b0) begin miscompares++; $display("FAIL ex_no_timeout got %b want 0", bus.ex_timeout_o); end
    tick();
  endtask

  task automatic test_watchdog();
    rst = 1'b1; drive(1'b0, 1'b0, 1'b0, 32'h0); tick(); rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      vectors++; if (bus_wd.stall_o !== ((c < 4) ? 6'b001111 : 6'b000000)) begin miscompares++; $display("FAIL wd_c%0d got %b want %b", c, bus_wd.stall_o, (c < 4) ? 6'b001111 : 6'b000000); end
      tick();
    end
    vectors++; if (bus_wd.ex_timeout_o !== 1'b1) begin miscompares++; $display("FAIL wd_timeout got %b want 1", bus_wd.ex_timeout_o); end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus_wd.stall_o !== 6'd0) begin miscompares++; $display("FAIL wd_drop got %b want 000000", bus_wd.stall_o); end
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    vectors++; if (bus_wd.stall_o !== 6'b001111) begin miscompares++; $display("FAIL wd_rerise got %b want 001111", bus_wd.stall_o); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    vectors++; if (bus_wd.ex_timeout_o !== 1'b1) begin miscompares++; $display("FAIL wd_sticky got %b want 1", bus_wd.ex_timeout_o); end
  endtask

  task automatic test_flush_priority();
    drive(1'b0, 1'b1, 1'b1, 32'h40);
    vectors++; if (bus.flush_o !== 1'b1) begin miscompares++; $display("FAIL flush_req got %b want 1", bus.flush_o); end
    vectors++; if (bus.new_pc_o !== 32'h40) begin miscompares++; $display("FAIL flush_req_pc got %h want 00000040", bus.new_pc_o); end
    vectors++; if (bus.stall_o !== 6'd0) begin miscompares++; $display("FAIL flush_req_stall got %b want 000000", bus.stall_o); end
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h80);
    vectors++; if (bus.flush_o !== 1'b1) begin miscompares++; $display("FAIL flush_hold got %b want 1", bus.flush_o); end
    vectors++; if (bus.new_pc_o !== 32'h40) begin miscompares++; $display("FAIL flush_hold_pc got %h want 00000040", bus.new_pc_o); end
    vectors++; if (bus.stall_o !== 6'd0) begin miscompares++; $display("FAIL flush_hold_stall got %b want 000000", bus.stall_o); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus.flush_o !== 1'b0) begin miscompares++; $display("FAIL flush_end got %b want 0", bus.flush_o); end
    vectors++; if (bus.new_pc_o !== 32'h40) begin miscompares++; $display("FAIL flush_end_pc got %h want 00000040", bus.new_pc_o); end
    tick();
  endtask

  task automatic test_reset_mid_ex();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      tick();
    end
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    vectors++; if (bus_wd.stall_o !== 6'd0) begin miscompares++; $display("FAIL rst_mid_stall got %b want 000000", bus_wd.stall_o); end
    tick();
    rst = 1'b0;
    vectors++; if (bus_wd.ex_timeout_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_timeout got %b want 0", bus_wd.ex_timeout_o); end
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      vectors++; if (bus_wd.stall_o !== ((c < 4) ? 6'b001111 : 6'b000000)) begin miscompares++; $display("FAIL rst_mid_c%0d got %b want %b", c, bus_wd.stall_o, (c < 4) ? 6'b001111 : 6'b000000); end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_perf();
    logic [31:0] exp_stall, exp_flush;
    rst = 1'b1; drive(1'b0, 1'b0, 1'b0, 32'h0); tick(); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin drive(c < 3, 1'b0, 1'b0, 32'h0); tick(); end
    drive(1'b0, 1'b0, 1'b1, 32'h100); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0); tick();
`ifdef PIPE_PERF_CNT_EN
    exp_stall = 32'd2; exp_flush = 32'd2;
`else
    exp_stall = 32'd0; exp_flush = 32'd0;
`endif
    vectors++; if (bus.perf_stall_cnt_o !== exp_stall) begin miscompares++; $display("FAIL perf_stall got %0d want %0d", bus.perf_stall_cnt_o, exp_stall); end
    vectors++; if (bus.perf_flush_cnt_o !== exp_flush) begin miscompares++; $display("FAIL perf_flush got %0d want %0d", bus.perf_flush_cnt_o, exp_flush); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; id_req = 1'b0; ex_req = 1'b0; br_req = 1'b0; br_tgt = 32'h0;
    tick();
    test_reset();
    test_load_use();
    test_ex_stall();
    test_watchdog();
    test_flush_priority();
    test_reset_mid_ex();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
